fifo_wr_ctrl: RTL and testbench
===============================

# fifo_wr_ctrl

Write-side pointer and flag controller for the async FIFO. It accepts write requests in the write clock domain and owns the binary write address and the Gray-coded write pointer. It also consumes the read pointer after the two-flop synchronizer has brought it into this domain, and from that pointer it generates full, almost-full, occupancy and overflow status for the writer. The FIFO memory and the read-domain synchronizer sit downstream of its waddr/wen and wptr outputs.

## Interface
- ASIZE, 4: address width; FIFO depth = 2^ASIZE; pointers are ASIZE+1 bits; ASIZE >= 2.
- AF_THRESH, 12: occupancy at or above which almost_full asserts; range 1..2^ASIZE.

- clk  in  1  write-domain clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_valid  in  1  writer requests a write this cycle.
- wr_ready  out  1  = !full; a write is accepted when wr_valid && wr_ready.
- rptr_sync  in  ASIZE+1  Gray read pointer, already synchronized into clk.
- clr_ovf  in  1  clears the sticky overflow flag.
- wen  out  1  memory write enable = wr_valid && !full (combinational).
- waddr  out  ASIZE  memory write address = wbin[ASIZE-1:0].
- wptr  out  ASIZE+1  registered Gray write pointer, to the read-domain synchronizer.
- full  out  1  registered full flag.
- almost_full  out  1  registered; occupancy >= AF_THRESH.
- wlevel  out  ASIZE+1  registered occupancy as seen from the write side, 0..2^ASIZE.
- overflow  out  1  sticky; set by a write attempt while full.

## Operation
- State: wbin (ASIZE+1, binary), wptr (Gray), full, almost_full, wlevel, overflow.
- wbin_next = wbin + wen, modulo 2^(ASIZE+1); wgray_next = (wbin_next >> 1) ^ wbin_next.
- full_next = (wgray_next == {~rptr_sync[ASIZE:ASIZE-1], rptr_sync[ASIZE-2:0]}).
- rbin = Gray-to-binary of rptr_sync, using the XOR prefix from the MSB down.
- wlevel_next = (wbin_next - rbin) modulo 2^(ASIZE+1); almost_full_next = (wlevel_next >= AF_THRESH).
- overflow: set when wr_valid && full. Cleared when clr_ovf is high and no set condition exists. If set and clear occur in the same cycle, set wins.
- Writes are dropped while full: wen=0, and wbin/wptr hold.
- Wrap-around: wbin rolls from 2^(ASIZE+1)-1 to 0; the Gray code rolls from {1,0...0} to 0 with a single bit change.
- Reset (any time, including mid-burst): all registers are cleared immediately. Clearing full makes wr_ready=1.

## Timing
- Reset values: wen=0 (while wr_valid=0), waddr=0, wptr=0, full=0, almost_full=0, wlevel=0, overflow=0, wr_ready=1.
- wen has zero latency from wr_valid. waddr and wptr advance on the clk edge that accepts the write.
- full asserts on the same edge that accepts the write filling the last entry. No write is accepted in the following cycle.
- full deasserts on the first clk edge after rptr_sync reflects a read. This makes full pessimistic by the synchronizer latency, which is required behaviour.
- wptr changes by at most one bit per cycle.
- wlevel and almost_full update on the same edges as full.
- overflow sets on the edge after the offending cycle.

## Configuration
- FIFO_WR_LEVEL_EN defined: the Gray-to-binary conversion, subtractor, wlevel and almost_full logic are built as specified.
- FIFO_WR_LEVEL_EN undefined: that logic is not built. wlevel is tied to 0 and almost_full is driven identically to full. All other behaviour is unchanged.

## Test plan
All scenarios use ASIZE=4, AF_THRESH=12, macro defined unless noted.
- Reset, then idle: all outputs read 0 and wr_ready=1. Asserting rst_n low mid-burst clears waddr, wptr and full within the same cycle, without waiting for a clock edge.
- 16 back-to-back writes with rptr_sync=0: waddr steps 0..15. After the 16th write: wptr=5'b11000, full=1, wlevel=16, almost_full=1 (first asserted after the 12th write).
- Continue writing while full: wen=0, waddr and wptr hold, overflow=1. Pulse clr_ovf with wr_valid=0: overflow=0. Pulse clr_ovf with wr_valid=1 and full=1: overflow stays 1.
- While full, set rptr_sync=5'b00001: full=0 and wlevel=15 on the next edge. The next write is accepted at waddr=0.
- Run 100 writes with rptr_sync tracking gray(wbin-3): wbin wraps 31 to 0 and wptr goes 5'b10000 to 5'b00000. full never asserts and wlevel stays at 3.
- Macro undefined, fill 16 entries: wlevel=0 throughout, and almost_full toggles exactly with full.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side pointer, full and overflow control of the async FIFO.
// Define FIFO_WR_LEVEL_EN to build the wlevel/almost_full occupancy logic.
module fifo_wr_ctrl #(
  parameter int ASIZE     = 4,
  parameter int AF_THRESH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [ASIZE:0]   rptr_sync,
  input  logic             clr_ovf,
  output logic             wen,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic             full,
  output logic             almost_full,
  output logic [ASIZE:0]   wlevel,
  output logic             overflow
);

  if (ASIZE < 2 || AF_THRESH < 1 || AF_THRESH > (1 << ASIZE)) begin : g_chk
    $error("fifo_wr_ctrl: bad ASIZE/AF_THRESH");
  end

  logic [ASIZE:0] r_wbin;
  logic [ASIZE:0] r_wptr;
  logic           r_full;
  logic           r_ovf;
  logic           w_wen;
  logic           w_full_nxt;
  logic [ASIZE:0] w_wbin_nxt;
  logic [ASIZE:0] w_wgray_nxt;
  logic [ASIZE:0] w_rptr_full;

  assign w_wen       = wr_valid & ~r_full;
  assign w_wbin_nxt  = r_wbin + {{ASIZE{1'b0}}, w_wen};
  assign w_wgray_nxt = (w_wbin_nxt >> 1) ^ w_wbin_nxt;
  // Full when the writer is one lap ahead: top two Gray bits differ.
  assign w_rptr_full = {~rptr_sync[ASIZE:ASIZE-1],
                        rptr_sync[ASIZE-2:0]};
  assign w_full_nxt  = (w_wgray_nxt == w_rptr_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbin <= '0;
      r_wptr <= '0;
      r_full <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_wbin <= w_wbin_nxt;
      r_wptr <= w_wgray_nxt;
      r_full <= w_full_nxt;
      r_ovf  <= (wr_valid & r_full) | (r_ovf & ~clr_ovf);
    end
  end

`ifdef FIFO_WR_LEVEL_EN
  localparam logic [ASIZE:0] LP_AF = (ASIZE+1)'(AF_THRESH);

  logic [ASIZE:0] w_rbin;
  logic [ASIZE:0] w_lvl_nxt;
  logic [ASIZE:0] r_lvl;
  logic           r_af;

  function automatic logic [ASIZE:0] g2b(input logic [ASIZE:0] g);
    logic [ASIZE:0] b;
    b[ASIZE] = g[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign w_rbin    = g2b(rptr_sync);
  assign w_lvl_nxt = w_wbin_nxt - w_rbin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl <= '0;
      r_af  <= 1'b0;
    end else begin
      r_lvl <= w_lvl_nxt;
      r_af  <= (w_lvl_nxt >= LP_AF);
    end
  end

  assign wlevel      = r_lvl;
  assign almost_full = r_af;
`else
  assign wlevel      = '0;
  assign almost_full = r_full;
`endif

  assign wr_ready = ~r_full;
  assign wen      = w_wen;
  assign waddr    = r_wbin[ASIZE-1:0];
  assign wptr     = r_wptr;
  assign full     = r_full;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: vector table, async reset, wrap and random checks
// of fifo_wr_ctrl against a write/read counter model.
module tb_fifo_wr_ctrl;

`ifdef FIFO_WR_LEVEL_EN
  localparam bit LVL_EN = 1'b1;
`else
  localparam bit LVL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] rptr_sync;
  logic       clr_ovf;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       full;
  logic       almost_full;
  logic [4:0] wlevel;
  logic       overflow;

  fifo_wr_ctrl #(.ASIZE(4), .AF_THRESH(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .rptr_sync   (rptr_sync),
    .clr_ovf     (clr_ovf),
    .wen         (wen),
    .waddr       (waddr),
    .wptr        (wptr),
    .full        (full),
    .almost_full (almost_full),
    .wlevel      (wlevel),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: total words written / read-pointer count seen
  int         wcnt;
  int         rcnt;
  bit         m_full;
  bit         m_ovf;
  logic [4:0] prev_wptr;

  typedef struct {
    logic       v;
    logic       c;
    logic [4:0] rp;
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       full;
    logic [4:0] lvl;
    logic       ovf;
  } vec_t;

  vec_t tbl[23];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] gray(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  function automatic int exp_lvl(input int l);
    return LVL_EN ? l : 0;
  endfunction

  function automatic logic exp_af(input int l, input logic f);
    return LVL_EN ? (l >= 12) : f;
  endfunction

  task automatic cyc(input logic v, input logic c, input int rc);
    int lvl;
    wr_valid  = v;
    clr_ovf   = c;
    rcnt      = rc;
    rptr_sync = gray(rc);
    #1;
    chk("wen", wen, v && !m_full);
    chk("wr_ready", wr_ready, !m_full);
    chk("waddr", waddr, wcnt % 16);
    @(posedge clk);
    m_ovf = (v && m_full) ? 1'b1 : (c ? 1'b0 : m_ovf);
    if (v && !m_full) wcnt++;
    lvl    = wcnt - rc;
    m_full = (lvl == 16);
    #1;
    chk("wptr", wptr, gray(wcnt));
    chk("full", full, m_full);
    chk("wlevel", wlevel, exp_lvl(lvl));
    chk("almost_full", almost_full, exp_af(lvl, m_full));
    chk("overflow", overflow, m_ovf);
    chk("wptr_step", $countones(prev_wptr ^ wptr) <= 1, 1);
    prev_wptr = wptr;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++)
      tbl[i] = '{v: 1'b1, c: 1'b0, rp: 5'd0, wen: 1'b1,
                 waddr: 4'(i), wptr: gray(i + 1),
                 full: (i == 15), lvl: 5'(i + 1), ovf: 1'b0};
    tbl[16] = '{1, 0, 0, 0, 0, 24, 1, 16, 1};
    tbl[17] = '{1, 0, 0, 0, 0, 24, 1, 16, 1};
    tbl[18] = '{0, 1, 0, 0, 0, 24, 1, 16, 0};
    tbl[19] = '{1, 1, 0, 0, 0, 24, 1, 16, 1};
    tbl[20] = '{0, 1, 0, 0, 0, 24, 1, 16, 0};
    tbl[21] = '{0, 0, 1, 0, 0, 24, 0, 15, 0};
    tbl[22] = '{1, 0, 1, 1, 0, 25, 1, 16, 0};

    rst_n     = 1'b0;
    wr_valid  = 1'b0;
    clr_ovf   = 1'b0;
    rptr_sync = '0;
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.wen", wen, 0);
    chk("rst.waddr", waddr, 0);
    chk("rst.wptr", wptr, 0);
    chk("rst.full", full, 0);
    chk("rst.af", almost_full, 0);
    chk("rst.wlevel", wlevel, 0);
    chk("rst.ovf", overflow, 0);
    chk("rst.wr_ready", wr_ready, 1);

    for (int i = 0; i < 23; i++) begin
      wr_valid  = tbl[i].v;
      clr_ovf   = tbl[i].c;
      rptr_sync = tbl[i].rp;
      #1;
      chk($sformatf("t%0d.wen", i), wen, tbl[i].wen);
      chk($sformatf("t%0d.waddr", i), waddr, tbl[i].waddr);
      @(posedge clk);
      #1;
      chk($sformatf("t%0d.wptr", i), wptr, tbl[i].wptr);
      chk($sformatf("t%0d.full", i), full, tbl[i].full);
      chk($sformatf("t%0d.wlevel", i), wlevel, exp_lvl(tbl[i].lvl));
      chk($sformatf("t%0d.af", i), almost_full,
          exp_af(tbl[i].lvl, tbl[i].full));
      chk($sformatf("t%0d.ovf", i), overflow, tbl[i].ovf);
    end

    wr_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.waddr", waddr, 0);
    chk("arst.wptr", wptr, 0);
    chk("arst.full", full, 0);
    chk("arst.wr_ready", wr_ready, 1);
    chk("arst.ovf", overflow, 0);
    wr_valid  = 1'b0;
    rptr_sync = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wcnt      = 0;
    rcnt      = 0;
    m_full    = 1'b0;
    m_ovf     = 1'b0;
    prev_wptr = '0;

    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 0);
    for (int k = 0; k < 100; k++) cyc(1'b1, 1'b0, wcnt - 2);
    chk("wrap.wlevel", wlevel, exp_lvl(3));

    for (int k = 0; k < 400; k++) begin
      logic v;
      logic c;
      int   rc;
      v  = ($urandom % 4) != 0;
      c  = ($urandom % 8) == 0;
      rc = rcnt;
      if (($urandom % 3) == 0 && rcnt < wcnt) rc = rcnt + 1;
      cyc(v, c, rc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
